seg_595_dyn_scan: RTL
=====================

Name: seg_595_dyn_scan

Overview:
- Parametrised successor to the static 74HC595 seven-segment driver.
- Time-multiplexes DIGITS segment patterns onto a daisy-chained 74HC595 pair: one segment register plus one digit-select register.
- For each digit it serialises a frame of {select, segments} on ds/shcp, latches it with stcp, then holds it for one scan slot.
- Sits between the display-data logic (BCD/segment decoder) and the board's 595 pins; output enable is gated by a blanking input.

Parameters:
- DIGITS, 6, number of multiplexed digits; width of the active-low one-hot select field (2..8).
- SEG_W, 8, segment bits per digit (a..g, dp), active-low patterns as supplied.
- CLK_DIV, 2, shcp half-period and stcp pulse width, in sys_clk cycles (>=1).
- SCAN_CYC, 50000, sys_clk cycles per digit slot. Must satisfy SCAN_CYC >= 1 + FRAME_W*2*CLK_DIV + CLK_DIV + 1.
- Derived: FRAME_W = SEG_W + DIGITS.

Ports:
- sys_clk  in  1  system clock (50 MHz).
- sys_rst_n  in  1  asynchronous active-low reset.
- seg_data  in  DIGITS*SEG_W  segment patterns; digit k occupies [k*SEG_W +: SEG_W].
- en  in  1  display enable; 0 blanks the display.
- ds  out  1  595 serial data.
- shcp  out  1  595 shift clock.
- stcp  out  1  595 storage (latch) clock.
- oe  out  1  595 output enable, active-low.
- digit_idx  out  $clog2(DIGITS)  digit currently being framed/displayed.
- frame_done  out  1  one-cycle pulse on the last LATCH cycle.

Behaviour:
- Reset (async assert, sync release). All outputs reset to: ds=0, shcp=0, stcp=0, oe=1, digit_idx=0, frame_done=0. State resets to IDLE and all counters to 0.
- Reset asserted mid-frame aborts the frame immediately. The partial 595 contents are never latched, because stcp is forced to 0.
- oe is registered as ~en. It is 1 while in reset and goes 0 one cycle after en=1 is sampled. Blanking does not stop scanning.
- Slot counter: 0..SCAN_CYC-1, free-running per slot. It restarts at 0 on entry to IDLE, so every slot is exactly SCAN_CYC cycles.
- FSM states: IDLE, SHIFT, LATCH, HOLD.
- IDLE (1 cycle):
  - Snapshot frame F = {sel_n, seg_data[digit_idx*SEG_W +: SEG_W]}.
  - sel_n is all ones except bit digit_idx = 0.
  - Then go to SHIFT.
- SHIFT (FRAME_W*2*CLK_DIV cycles):
  - Bit b = 0..FRAME_W-1 is sent LSB first, F[0] first.
  - Each bit lasts 2*CLK_DIV cycles; ds = F[b] for the whole bit period.
  - shcp = 0 for phases 0..CLK_DIV-1 and 1 for phases CLK_DIV..2*CLK_DIV-1, so the rising edge falls at mid-bit with ds stable.
  - After the last phase of bit FRAME_W-1, go to LATCH with shcp=0.
- LATCH (CLK_DIV cycles): stcp=1, ds=0, shcp=0; frame_done=1 on the final cycle. Then go to HOLD.
- HOLD: stcp=0. When the slot counter reaches SCAN_CYC-1:
  - digit_idx increments, wrapping from DIGITS-1 to 0.
  - Go to IDLE.
- seg_data changes are seen only at the IDLE snapshot; mid-frame changes do not corrupt the frame in flight.
- shcp and stcp are never high simultaneously.
- The first frame after reset starts in the first cycle after sys_rst_n deasserts and uses digit 0.

Decomposition:
- Package seg595_pkg: FSM state enum (IDLE/SHIFT/LATCH/HOLD), FRAME_W and index-width constant functions.
- One sub-module hc595_serializer (parameters W, CLK_DIV):
  - Interface: start/frame[W-1:0] in; ds/shcp/stcp/done out.
  - Implements the SHIFT and LATCH phases.
  - The top level owns the slot counter, digit_idx, frame build and oe.

Test Plan (DIGITS=2, SEG_W=8, CLK_DIV=1, SCAN_CYC=40, FRAME_W=10, seg_data = {8'hF9, 8'hC0}, en=1):
- Reset: hold sys_rst_n=0 for 3 cycles -> oe=1, ds=shcp=stcp=0, digit_idx=0. After release, the first shcp rise occurs on cycle 2.
- Digit 0 frame: F = 10'b10_1100_0000. On successive shcp rises ds = 0,0,0,0,0,0,1,1,0,1. Exactly 10 shcp rises, then one stcp=1 cycle with frame_done=1.
- Digit 1 frame: the next IDLE comes 40 cycles after the first. ds at the rises = 1,0,0,1,1,1,1,1,1,0. digit_idx=1. The following slot wraps to digit_idx=0.
- Blanking: drop en for 100 cycles -> oe=1 one cycle later. Frames and stcp pulses continue unchanged; oe=0 returns one cycle after en=1.
- Mid-frame data change: change seg_data[7:0] to 8'hA4 during SHIFT of digit 0 -> the current frame is still 0xC0; the next digit-0 frame carries 0xA4.
- Reset mid-SHIFT: assert sys_rst_n=0 at bit 5 -> no stcp pulse. Outputs take their reset values asynchronously, and after release the frame restarts at digit 0, bit 0.

Source files
------------

// File: rtl/seg595_pkg.sv
// Shared types and sizing helpers for the multiplexed 74HC595 seven-segment scanner.
package seg595_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      LATCH,
      HOLD
   } state_t;

   function automatic int frame_w(input int digits, input int seg_w);
      return digits + seg_w;
   endfunction

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hc595_serializer.sv
// Shifts one W-bit frame LSB first into a 595 chain, then pulses the storage clock.
module hc595_serializer
   import seg595_pkg::*;
#(
   parameter int W       = 14,
   parameter int CLK_DIV = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] frame,
   output logic         ds,
   output logic         shcp,
   output logic         stcp,
   output logic         done
);

   localparam int BIT_W = idx_w(W);
   localparam int PH_W  = idx_w(2 * CLK_DIV);
   localparam int LAT_W = idx_w(CLK_DIV);

   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(W - 1);
   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * CLK_DIV - 1);
   localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(CLK_DIV);
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(CLK_DIV - 1);

   state_t             mode_reg, mode_next;
   logic [W-1:0]       shift_reg, shift_next;
   logic [BIT_W-1:0]   bit_reg, bit_next;
   logic [PH_W-1:0]    ph_reg, ph_next;
   logic [LAT_W-1:0]   lat_reg, lat_next;
   logic               ds_reg, shcp_reg, stcp_reg, done_reg;
   logic               ds_next, shcp_next, stcp_next, done_next;

   always_comb begin
      mode_next  = mode_reg;
      shift_next = shift_reg;
      bit_next   = bit_reg;
      ph_next    = ph_reg;
      lat_next   = lat_reg;
      case (mode_reg)
         SHIFT: begin
            if (ph_reg == PH_LAST) begin
               ph_next = '0;
               if (bit_reg == BIT_LAST) begin
                  mode_next = LATCH;
                  lat_next  = '0;
               end else begin
                  bit_next   = bit_reg + 1'b1;
                  shift_next = shift_reg >> 1;
               end
            end else begin
               ph_next = ph_reg + 1'b1;
            end
         end
         LATCH: begin
            if (lat_reg == LAT_LAST) begin
               mode_next = IDLE;
            end else begin
               lat_next = lat_reg + 1'b1;
            end
         end
         default: begin
            if (start) begin
               mode_next  = SHIFT;
               shift_next = frame;
               bit_next   = '0;
               ph_next    = '0;
            end
         end
      endcase
   end

   // Pin levels are derived from the next state and registered, so they are
   // glitch-free and line up exactly with the phase they describe.
   always_comb begin
      ds_next   = (mode_next == SHIFT) & shift_next[0];
      shcp_next = (mode_next == SHIFT) && (ph_next >= PH_HALF);
      stcp_next = (mode_next == LATCH);
      done_next = (mode_next == LATCH) && (lat_next == LAT_LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_reg  <= IDLE;
         shift_reg <= '0;
         bit_reg   <= '0;
         ph_reg    <= '0;
         lat_reg   <= '0;
         ds_reg    <= 1'b0;
         shcp_reg  <= 1'b0;
         stcp_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         mode_reg  <= mode_next;
         shift_reg <= shift_next;
         bit_reg   <= bit_next;
         ph_reg    <= ph_next;
         lat_reg   <= lat_next;
         ds_reg    <= ds_next;
         shcp_reg  <= shcp_next;
         stcp_reg  <= stcp_next;
         done_reg  <= done_next;
      end
   end

   assign ds   = ds_reg;
   assign shcp = shcp_reg;
   assign stcp = stcp_reg;
   assign done = done_reg;

endmodule

// File: rtl/seg_595_dyn_scan.sv
// Time-multiplexed seven-segment driver: one {digit-select, segments} frame per
// scan slot, shifted into a daisy-chained 74HC595 pair.
module seg_595_dyn_scan
   import seg595_pkg::*;
#(
   parameter int DIGITS   = 6,
   parameter int SEG_W    = 8,
   parameter int CLK_DIV  = 2,
   parameter int SCAN_CYC = 50000
) (
   input  logic                      sys_clk,
   input  logic                      sys_rst_n,
   input  logic [DIGITS*SEG_W-1:0]   seg_data,
   input  logic                      en,
   output logic                      ds,
   output logic                      shcp,
   output logic                      stcp,
   output logic                      oe,
   output logic [$clog2(DIGITS)-1:0] digit_idx,
   output logic                      frame_done
);

   localparam int FRAME_W = frame_w(DIGITS, SEG_W);
   localparam int IDX_W   = $clog2(DIGITS);
   localparam int SLOT_W  = idx_w(SCAN_CYC);

   localparam logic [IDX_W-1:0]  DIG_LAST  = IDX_W'(DIGITS - 1);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_CYC - 1);

   state_t              state_reg, state_next;
   logic [SLOT_W-1:0]   slot_reg, slot_next;
   logic [IDX_W-1:0]    digit_reg, digit_next;
   logic                oe_reg;

   logic [SEG_W-1:0]    seg_arr [DIGITS];
   logic [DIGITS-1:0]   sel_n;
   logic [FRAME_W-1:0]  frame;
   logic                ser_start, ser_ds, ser_shcp, ser_stcp, ser_done;

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign seg_arr[gi] = seg_data[gi*SEG_W +: SEG_W];
      assign sel_n[gi]   = (digit_reg != IDX_W'(gi));
   end

   // The serializer copies this frame when it accepts start, which is the
   // snapshot that keeps later seg_data changes out of the frame in flight.
   assign frame     = {sel_n, seg_arr[digit_reg]};
   assign ser_start = (state_reg == IDLE);

   always_comb begin
      state_next = state_reg;
      digit_next = digit_reg;
      case (state_reg)
         IDLE: state_next = SHIFT;
         SHIFT: begin
            if (ser_done) begin
               state_next = HOLD;
            end else if (ser_stcp) begin
               state_next = LATCH;
            end
         end
         LATCH: begin
            if (ser_done) begin
               state_next = HOLD;
            end
         end
         HOLD: begin
            if (slot_reg == SLOT_LAST) begin
               state_next = IDLE;
               digit_next = (digit_reg == DIG_LAST) ? '0 : digit_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
      slot_next = (state_next == IDLE) ? '0 : slot_reg + 1'b1;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_reg <= IDLE;
         slot_reg  <= '0;
         digit_reg <= '0;
         oe_reg    <= 1'b1;
      end else begin
         state_reg <= state_next;
         slot_reg  <= slot_next;
         digit_reg <= digit_next;
         oe_reg    <= ~en;
      end
   end

   hc595_serializer #(
      .W       (FRAME_W),
      .CLK_DIV (CLK_DIV)
   ) u_ser (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .start (ser_start),
      .frame (frame),
      .ds    (ser_ds),
      .shcp  (ser_shcp),
      .stcp  (ser_stcp),
      .done  (ser_done)
   );

   assign ds         = ser_ds;
   assign shcp       = ser_shcp;
   assign stcp       = ser_stcp;
   assign frame_done = ser_done;
   assign oe         = oe_reg;
   assign digit_idx  = digit_reg;

endmodule
